i2s_sample_scheduler: RTL and testbench
=======================================

// Module: i2s_sample_scheduler
//
// PURPOSE
//  Feeds stereo 16-bit samples into the I2Sb transmitter via its byte-wide register bus (wd/A/din).
//  Two sample producers share one FIFO under round-robin arbitration: req0 is scope playback, req1 is the test-tone generator.
//  On every new I2S frame it pops one {L,R} pair and issues four byte writes to I2Sb.
//  On FIFO underrun it substitutes a fallback sample.
//
// PARAMETERS
//  FIFO_DEPTH     8   sample-pair FIFO depth; power of 2, >=2
//  UNDERRUN_ZERO  0   1: write 0x0000/0x0000 on underrun; 0: repeat last sent pair
//
// PORTS
//  clk         in   1   system clock; same clock as I2Sb
//  reset       in   1   synchronous, active-high
//  enable      in   1   1: service frames; 0: ignore frame starts, FIFO retained
//  flush       in   1   1-cycle pulse: empty the FIFO
//  req0_valid  in   1   producer 0 has a sample pair
//  req0_data   in   32  {L[15:0],R[15:0]}
//  req0_ready  out  1   pair accepted this cycle
//  req1_valid  in   1   producer 1 has a sample pair
//  req1_data   in   32  {L[15:0],R[15:0]}
//  req1_ready  out  1   pair accepted this cycle
//  lrck        in   1   word clock from I2Sb; asynchronous to clk-domain logic
//  wd          out  1   register write strobe to I2Sb
//  A           out  2   register address to I2Sb
//  din         out  8   register write data to I2Sb
//  fifo_level  out  $clog2(FIFO_DEPTH)+1   current occupancy
//  underrun    out  1   sticky: a frame found the FIFO empty; cleared by reset only
//  overrun     out  1   sticky: a frame start arrived while a write burst was busy
//
// BEHAVIOUR
//  Reset values:
//   - wd=0, A=0, din=0, req*_ready=0, fifo_level=0, underrun=0, overrun=0
//   - last pair=0; round-robin priority points to req0
//  Arbitration:
//   - At most one push per cycle; a push is allowed only when fifo_level<FIFO_DEPTH.
//   - Full is evaluated on the registered count, so a same-cycle pop does not admit a push when full.
//   - With both producers valid, the grant alternates; priority flips to the other producer after every grant.
//   - With one producer valid, that producer is granted.
//   - reqN_ready is combinational: grant & !full & !flush.
//  Frame detect:
//   - lrck passes through a 2-FF synchroniser.
//   - frame_start = synchronised lrck falls 1->0, held 1 cycle.
//  FSM states: IDLE -> WR0 -> WR1 -> WR2 -> WR3 -> IDLE.
//   - IDLE: on frame_start & enable, pop the FIFO if non-empty, else raise underrun and use the fallback pair; go to WR0.
//   - WR0..WR3: wd=1 for one cycle each, on consecutive cycles:
//       WR0: A=0, din=L[7:0]
//       WR1: A=1, din=L[15:8]
//       WR2: A=2, din=R[7:0]
//       WR3: A=3, din=R[15:8]
//   - Outside WR states: wd=0 and A/din hold 0.
//   - Latency: WR0 is the cycle after the frame_start cycle; the burst is 4 cycles.
//  Boundary cases:
//   - frame_start in a WR state: ignored, overrun=1.
//   - flush in the same cycle as a pop: flush wins, the popped pair is still sent, and the FIFO ends empty.
//   - Push and pop in the same cycle with the FIFO not full: level unchanged.
//   - enable falling mid-burst: the burst completes.
//   - reset mid-burst: wd drops to 0 the next cycle; the FIFO and the last pair are cleared.
//   - Pointers wrap modulo FIFO_DEPTH.
//
// CONFIGURATION
//  Macro I2S_SCHED_FRAMECNT_EN:
//   - Defined: adds output frame_cnt[15:0]. It is reset to 0, increments on every serviced frame, and wraps at 0xFFFF->0.
//   - Undefined: the port and its counter are absent; all other behaviour is identical.
//
// STRUCTURE
//  Package i2s_sched_pkg:
//   - I2S register addresses ADDR_LL=0, ADDR_LH=1, ADDR_RL=2, ADDR_RH=3
//   - FSM state enum
//   - sample-pair typedef (32-bit {L,R})
//  Sub-module sample_fifo: synchronous FIFO with push/pop/flush and level output, parameterised by FIFO_DEPTH.
//  The arbiter, synchroniser and FSM live in this module.
//
// TESTING
//  1. Reset with lrck toggling -> wd stays 0; level=0, underrun=0.
//  2. req0 pushes {0x1234,0xABCD}, then an lrck fall -> cycles WR0..WR3 show A/din = 0/34, 1/12, 2/CD, 3/AB; level back to 0.
//  3. req0 and req1 both valid continuously with FIFO_DEPTH=8 -> grants alternate 0,1,0,1...; readies drop at level=8.
//  4. Empty FIFO at a frame with UNDERRUN_ZERO=0 after pair 0x1234/0xABCD -> the same 4 bytes are written again and underrun=1.
//     With UNDERRUN_ZERO=1 -> four 0x00 writes.
//  5. Force an lrck fall during WR1 -> burst unaffected, overrun=1, no extra pop.
//  6. flush with level=5 -> level=0 the next cycle; the next frame underruns.
//     With I2S_SCHED_FRAMECNT_EN defined, 3 serviced frames -> frame_cnt=3.

Source files
------------

// File: rtl/i2s_sched_pkg.sv
// Shared definitions for the I2S sample scheduler: I2Sb register
// addresses, the write-burst FSM state encoding and the {L,R} sample pair.
package i2s_sched_pkg;

  localparam logic [1:0] ADDR_LL = 2'd0;
  localparam logic [1:0] ADDR_LH = 2'd1;
  localparam logic [1:0] ADDR_RL = 2'd2;
  localparam logic [1:0] ADDR_RH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3
  } state_e;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample-pair FIFO with push/pop/flush and an occupancy count.
// The head entry is presented combinationally so a pop and the use of the
// popped pair can happen in the same cycle. Flush overrides push and pop.
module sample_fifo
  import i2s_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  pair_t                    push_data,
  input  logic                     pop,
  input  logic                     flush,
  output pair_t                    head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  pair_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            do_push;
  logic            do_pop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

  // Storage array; written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// I2S sample scheduler: arbitrates two sample producers into a shared FIFO
// and, on every I2S frame start, writes one {L,R} pair to I2Sb as four byte
// writes. Optional feature macro I2S_SCHED_FRAMECNT_EN adds a 16-bit count
// of serviced frames on output frame_cnt.
module i2s_sample_scheduler
  import i2s_sched_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          req0_valid,
  input  logic [31:0]                   req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [31:0]                   req1_data,
  output logic                          req1_ready,
  input  logic                          lrck,
  output logic                          wd,
  output logic [1:0]                    A,
  output logic [7:0]                    din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          overrun
`ifdef I2S_SCHED_FRAMECNT_EN
  ,output logic [15:0]                  frame_cnt
`endif
);

  logic   lrck_s1_q, lrck_s2_q, lrck_s3_q;
  logic   frame_start;
  logic   prio_q;
  logic   grant0, grant1, accept_ok, push;
  pair_t  push_data;
  pair_t  fifo_head;
  logic   fifo_empty, fifo_full;
  logic   service, pop;
  pair_t  pair_d, pair_q;
  state_e state_q;
  logic   wd_q, underrun_q, overrun_q;
  logic [1:0] addr_q;
  logic [7:0] din_q;

  // Two-stage synchroniser for lrck plus a delay stage for fall detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      lrck_s3_q <= 1'b0;
    end else begin
      lrck_s1_q <= lrck;
      lrck_s2_q <= lrck_s1_q;
      lrck_s3_q <= lrck_s2_q;
    end
  end

  assign frame_start = lrck_s3_q & ~lrck_s2_q;

  // Round-robin arbitration; prio_q=0 favours req0 when both are valid.
  assign grant0     = req0_valid & (~req1_valid | ~prio_q);
  assign grant1     = req1_valid & (~req0_valid |  prio_q);
  assign accept_ok  = ~fifo_full & ~flush & ~reset;
  assign req0_ready = grant0 & accept_ok;
  assign req1_ready = grant1 & accept_ok;
  assign push       = req0_ready | req1_ready;
  assign push_data  = req0_ready ? pair_t'(req0_data) : pair_t'(req1_data);

  // Priority moves to the producer that was not just granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (push) begin
      prio_q <= req0_ready;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (fifo_head),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign service = (state_q == ST_IDLE) & frame_start & enable;
  assign pop     = service & ~fifo_empty;
  assign pair_d  = !fifo_empty ? fifo_head : (UNDERRUN_ZERO ? pair_t'('0) : pair_q);

  // Write-burst FSM with registered bus outputs; pair_q doubles as last-sent pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wd_q       <= 1'b0;
      addr_q     <= 2'd0;
      din_q      <= 8'd0;
      pair_q     <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (frame_start && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (service) begin
            pair_q  <= pair_d;
            if (fifo_empty) underrun_q <= 1'b1;
            state_q <= ST_WR0;
            wd_q    <= 1'b1;
            addr_q  <= ADDR_LL;
            din_q   <= pair_d.l[7:0];
          end
        end
        ST_WR0: begin
          state_q <= ST_WR1;
          addr_q  <= ADDR_LH;
          din_q   <= pair_q.l[15:8];
        end
        ST_WR1: begin
          state_q <= ST_WR2;
          addr_q  <= ADDR_RL;
          din_q   <= pair_q.r[7:0];
        end
        ST_WR2: begin
          state_q <= ST_WR3;
          addr_q  <= ADDR_RH;
          din_q   <= pair_q.r[15:8];
        end
        default: begin
          state_q <= ST_IDLE;
          wd_q    <= 1'b0;
          addr_q  <= 2'd0;
          din_q   <= 8'd0;
        end
      endcase
    end
  end

  assign wd       = wd_q;
  assign A        = addr_q;
  assign din      = din_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

`ifdef I2S_SCHED_FRAMECNT_EN
  logic [15:0] frame_cnt_q;

  // Count of serviced frames, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else if (service) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Directed testbench for i2s_sample_scheduler. A second instance built with
// UNDERRUN_ZERO=1 shares all inputs so both underrun fallbacks are covered.
module tb_i2s_sample_scheduler;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, flush, lrck;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;

  logic        req0_ready, req1_ready, wd, underrun, overrun;
  logic [1:0]  A;
  logic [7:0]  din;
  logic [3:0]  fifo_level;

  logic        req0_ready_z, req1_ready_z, wd_z, underrun_z, overrun_z;
  logic [1:0]  a_z;
  logic [7:0]  din_z;
  logic [3:0]  fifo_level_z;
`ifdef I2S_SCHED_FRAMECNT_EN
  logic [15:0] frame_cnt, frame_cnt_z;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  i2s_sample_scheduler #(.FIFO_DEPTH(DEPTH), .UNDERRUN_ZERO(1'b0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .lrck(lrck), .wd(wd), .A(A), .din(din), .fifo_level(fifo_level),
    .underrun(underrun), .overrun(overrun)
`ifdef I2S_SCHED_FRAMECNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  i2s_sample_scheduler #(.FIFO_DEPTH(DEPTH), .UNDERRUN_ZERO(1'b1)) dut_z (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready_z),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready_z),
    .lrck(lrck), .wd(wd_z), .A(a_z), .din(din_z), .fifo_level(fifo_level_z),
    .underrun(underrun_z), .overrun(overrun_z)
`ifdef I2S_SCHED_FRAMECNT_EN
    , .frame_cnt(frame_cnt_z)
`endif
  );

  // Drives one lrck fall (optionally a second fall landing in WR1) and checks the burst.
  task automatic run_frame(input logic [31:0] exp, input logic [31:0] exp_z, input bit inject, input string name);
    logic [7:0] eb [4];
    logic [7:0] ezb [4];
    eb[0]  = exp[23:16];   eb[1]  = exp[31:24];   eb[2]  = exp[7:0];   eb[3]  = exp[15:8];
    ezb[0] = exp_z[23:16]; ezb[1] = exp_z[31:24]; ezb[2] = exp_z[7:0]; ezb[3] = exp_z[15:8];
    lrck = 1'b1;
    repeat (4) @(negedge clk);
    lrck = 1'b0;
    @(negedge clk);
    if (inject) lrck = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wd !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early_wd: wd=%b required 0", name, wd);
    end
    if (inject) lrck = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (wd !== 1'b1 || A !== k[1:0] || din !== eb[k]) begin
        n_fail++;
        $display("FAIL %s byte%0d: wd=%b A=%0d din=%h, required wd=1 A=%0d din=%h", name, k, wd, A, din, k, eb[k]);
      end
      n_checks++;
      if (wd_z !== 1'b1 || a_z !== k[1:0] || din_z !== ezb[k]) begin
        n_fail++;
        $display("FAIL %s zero_byte%0d: wd=%b A=%0d din=%h, required wd=1 A=%0d din=%h", name, k, wd_z, a_z, din_z, k, ezb[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (wd !== 1'b0 || A !== 2'd0 || din !== 8'd0) begin
      n_fail++;
      $display("FAIL %s post_burst: wd=%b A=%0d din=%h, required 0/0/00", name, wd, A, din);
    end
    $display("frame %s: sent %h", name, exp);
  endtask

  // Single push from one producer; called and returns just after a negedge.
  task automatic push_one(input bit which, input logic [31:0] d, input string name);
    logic rdy;
    if (which) begin req1_valid = 1'b1; req1_data = d; end
    else       begin req0_valid = 1'b1; req0_data = d; end
    #1;
    rdy = which ? req1_ready : req0_ready;
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s push_ready: ready=%b required 1", name, rdy);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("push %s: producer %0d data %h", name, which, d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (wd !== 1'b0 || req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: wd=%b req0_ready=%b required 0/0", wd, req0_ready);
      end
      lrck = ~lrck;
    end
    lrck = 1'b1;
    req0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 4'd0 || underrun !== 1'b0 || overrun !== 1'b0 || wd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: level=%0d underrun=%b overrun=%b wd=%b required 0/0/0/0", fifo_level, underrun, overrun, wd);
    end
    $display("reset: released");
  endtask

  task automatic test_basic();
    push_one(1'b0, 32'h1234ABCD, "basic");
    n_checks++;
    if (fifo_level !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_level_after_push: level=%0d required 1", fifo_level);
    end
    run_frame(32'h1234ABCD, 32'h1234ABCD, 1'b0, "basic");
    n_checks++;
    if (fifo_level !== 4'd0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: level=%0d underrun=%b required 0/0", fifo_level, underrun);
    end
  endtask

  task automatic test_underrun();
    run_frame(32'h1234ABCD, 32'h0000_0000, 1'b0, "underrun");
    n_checks++;
    if (underrun !== 1'b1 || underrun_z !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_flag: underrun=%b zero_inst=%b required 1/1", underrun, underrun_z);
    end
  endtask

  // Both producers valid every cycle; priority currently points at req1.
  task automatic test_arbitration();
    for (int k = 0; k <= DEPTH; k++) begin
      req0_valid = 1'b1; req0_data = {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
      req1_valid = 1'b1; req1_data = {16'h3000 + 16'(k), 16'h4000 + 16'(k)};
      #1;
      n_checks++;
      if (fifo_level !== 4'(k)) begin
        n_fail++;
        $display("FAIL arb_level%0d: level=%0d required %0d", k, fifo_level, k);
      end
      n_checks++;
      if (k == DEPTH) begin
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL arb_full: ready0=%b ready1=%b required 0/0", req0_ready, req1_ready);
        end
      end else if (req1_ready !== ((k % 2) == 0) || req0_ready !== ((k % 2) == 1)) begin
        n_fail++;
        $display("FAIL arb_grant%0d: ready0=%b ready1=%b required %b/%b", k, req0_ready, req1_ready, (k % 2) == 1, (k % 2) == 0);
      end
      $display("arb cycle %0d: ready0=%b ready1=%b level=%0d", k, req0_ready, req1_ready, fifo_level);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    run_frame(32'h30004000, 32'h30004000, 1'b0, "order0");
    run_frame(32'h10012001, 32'h10012001, 1'b0, "order1");
    run_frame(32'h30024002, 32'h30024002, 1'b0, "order2");
    n_checks++;
    if (fifo_level !== 4'd5) begin
      n_fail++;
      $display("FAIL arb_level_after_pops: level=%0d required 5", fifo_level);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    req0_valid = 1'b1;
    req0_data = 32'hDEADDEAD;
    #1;
    n_checks++;
    if (req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: ready=%b required 0", req0_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    req0_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_level: level=%0d required 0", fifo_level);
    end
    $display("flush: level now %0d", fifo_level);
    run_frame(32'h30024002, 32'h0000_0000, 1'b0, "post_flush");
  endtask

  task automatic test_enable();
    push_one(1'b0, 32'h0BADF00D, "enable");
    enable = 1'b0;
    lrck = 1'b1;
    repeat (4) @(negedge clk);
    lrck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (wd !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_wd%0d: wd=%b required 0", i, wd);
      end
    end
    n_checks++;
    if (fifo_level !== 4'd1) begin
      n_fail++;
      $display("FAIL disabled_level: level=%0d required 1", fifo_level);
    end
    enable = 1'b1;
    run_frame(32'h0BADF00D, 32'h0BADF00D, 1'b0, "reenabled");
  endtask

  task automatic test_overrun();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_pre: overrun=%b required 0", overrun);
    end
    push_one(1'b1, 32'hCAFEBEEF, "ovr_a");
    push_one(1'b1, 32'h55AA0FF0, "ovr_b");
    run_frame(32'hCAFEBEEF, 32'hCAFEBEEF, 1'b1, "overrun");
    n_checks++;
    if (overrun !== 1'b1 || fifo_level !== 4'd1) begin
      n_fail++;
      $display("FAIL overrun_after: overrun=%b level=%0d required 1/1", overrun, fifo_level);
    end
    run_frame(32'h55AA0FF0, 32'h55AA0FF0, 1'b0, "after_overrun");
    n_checks++;
    if (fifo_level !== 4'd0 || underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_final: level=%0d underrun=%b required 0/1", fifo_level, underrun);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0; lrck = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_arbitration();
    test_flush();
    test_enable();
    test_overrun();
`ifdef I2S_SCHED_FRAMECNT_EN
    n_checks++;
    if (frame_cnt !== 16'd9) begin
      n_fail++;
      $display("FAIL frame_cnt: value=%0d required 9", frame_cnt);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
